// File: rtl/arb_pkg.sv
// Shared types and constants for the L2 port arbiter.
//   arb_state_t : grant state (idle, instruction owner, data owner)
//   LINE_W      : cache line width in bits
//   ADDR_W      : line address width in bits
//   STREAK_W    : width of the starvation streak counter
package arb_pkg;

    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 32;
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_INSTR = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating streak counter that tracks consecutive data grants taken
// while an instruction request was waiting.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   i_inc       : count one data grant made over a waiting instr request
//   i_clr       : clear (instruction grant); wins over i_inc
//   o_limit_hit : count has reached LIMIT
//   o_count     : current count (debug visibility)
module arb_streak_counter
    import arb_pkg::*;
#(
    parameter logic [STREAK_W-1:0] LIMIT = 4'd4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_inc,
    input  logic                i_clr,
    output logic                o_limit_hit,
    output logic [STREAK_W-1:0] o_count
);

    logic [STREAK_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_limit_hit = (r_count == LIMIT);
    assign o_count     = r_count;

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 port between the I-cache and D-cache miss paths. One
// transaction is outstanding at a time; the grant is held until L2_resp
// and the response is routed back to the owner.
//
// Handshake: a requester is pending while its read|write is 1. Once
// granted, its live read/write/addr/wdata drive L2 until L2_resp pulses.
// The owner's *_resp is combinational with L2_resp; the requester drops
// its request the following cycle, and the arbiter always spends one
// cycle in ARB_IDLE after a response so a stale request is never
// re-granted. *_rdata mirror L2_rdata and are qualified only by *_resp.
//
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   instr_read/write/addr/wdata     : I-cache request
//   data_read/write/addr/wdata      : D-cache request
//   L2_resp, L2_rdata               : L2 completion and read line
//   instr_resp/rdata, data_resp/rdata : routed completions
//   L2_read/write/addr/wdata        : L2 command (zero when idle)
//   busy                            : a grant is held
//   o_dbg_state, o_dbg_streak       : FSM state and streak count
module l2_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_read,
    input  logic                instr_write,
    input  logic [ADDR_W-1:0]   instr_addr,
    input  logic [LINE_W-1:0]   instr_wdata,
    input  logic                data_read,
    input  logic                data_write,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [LINE_W-1:0]   data_wdata,
    input  logic                L2_resp,
    input  logic [LINE_W-1:0]   L2_rdata,
    output logic                instr_resp,
    output logic [LINE_W-1:0]   instr_rdata,
    output logic                data_resp,
    output logic [LINE_W-1:0]   data_rdata,
    output logic                L2_read,
    output logic                L2_write,
    output logic [ADDR_W-1:0]   L2_addr,
    output logic [LINE_W-1:0]   L2_wdata,
    output logic                busy,
    output arb_state_t          o_dbg_state,
    output logic [STREAK_W-1:0] o_dbg_streak
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       w_instr_pend;
    logic       w_data_pend;
    logic       w_limit_hit;
    logic       w_streak_inc;
    logic       w_streak_clr;

    assign w_instr_pend = instr_read | instr_write;
    assign w_data_pend  = data_read | data_write;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_streak_inc = 1'b0;
        w_streak_clr = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                // Data wins a tie unless instr has waited out its streak.
                if (w_data_pend && (!w_instr_pend || !w_limit_hit)) begin
                    w_next_state = ARB_DATA;
                    w_streak_inc = w_instr_pend;
                end else if (w_instr_pend) begin
                    w_next_state = ARB_INSTR;
                    w_streak_clr = 1'b1;
                end
            end
            ARB_INSTR, ARB_DATA: begin
                if (L2_resp) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    arb_streak_counter #(
        .LIMIT (STREAK_W'(STARVE_LIMIT))
    ) u_streak (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_inc       (w_streak_inc),
        .i_clr       (w_streak_clr),
        .o_limit_hit (w_limit_hit),
        .o_count     (o_dbg_streak)
    );

    // L2 command mux: the owner's live inputs pass straight through.
    always_comb begin
        L2_read  = 1'b0;
        L2_write = 1'b0;
        L2_addr  = '0;
        L2_wdata = '0;
        case (r_state)
            ARB_INSTR: begin
                L2_read  = instr_read;
                L2_write = instr_write;
                L2_addr  = instr_addr;
                L2_wdata = instr_wdata;
            end
            ARB_DATA: begin
                L2_read  = data_read;
                L2_write = data_write;
                L2_addr  = data_addr;
                L2_wdata = data_wdata;
            end
            default: ;
        endcase
    end

    assign instr_resp  = L2_resp && (r_state == ARB_INSTR);
    assign data_resp   = L2_resp && (r_state == ARB_DATA);
    assign instr_rdata = L2_rdata;
    assign data_rdata  = L2_rdata;
    assign busy        = (r_state != ARB_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Shares the single L2 port between the L1 instruction-cache and data-cache miss paths. Holds one outstanding L2 transaction at a time, locks the grant until `L2_resp`, and routes the response to the owning cache. Data misses win by default, and a streak counter stops instruction fetch from starving under back-to-back data traffic. Sits between the two pipelined L1 caches and the L2 interface inside the L1 wrapper.

## Interface
- `STARVE_LIMIT`, 4: number of consecutive data grants allowed while an instruction request waits; range 1..15.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `instr_read`  in  1  I-cache line fill request.
- `instr_write`  in  1  I-cache writeback request; normally 0.
- `instr_addr`  in  32  I-cache line address.
- `instr_wdata`  in  256  I-cache writeback line.
- `data_read`  in  1  D-cache line fill request.
- `data_write`  in  1  D-cache writeback request.
- `data_addr`  in  32  D-cache line address.
- `data_wdata`  in  256  D-cache writeback line.
- `L2_resp`  in  1  L2 completion pulse.
- `L2_rdata`  in  256  L2 read line.
- `instr_resp`  out  1  completion to the I-cache.
- `instr_rdata`  out  256  fill line to the I-cache.
- `data_resp`  out  1  completion to the D-cache.
- `data_rdata`  out  256  fill line to the D-cache.
- `L2_read`, `L2_write`  out  1  L2 command.
- `L2_addr`  out  32  L2 address.
- `L2_wdata`  out  256  L2 write line.
- `busy`  out  1  a grant is held.

## Operation
- States: `ARB_IDLE`, `ARB_INSTR`, `ARB_DATA`. The state register is the only grant storage.
- A requester is pending when its `read | write` is 1.
- Decision in `ARB_IDLE`:
  - Only one requester pending: it wins.
  - Both pending: data wins unless `streak == STARVE_LIMIT`, in which case instr wins.
  - Neither pending: stay in `ARB_IDLE`.
- `streak` counter:
  - Increments on each data grant made while instr is pending, saturating at `STARVE_LIMIT`.
  - Clears on any instr grant.
  - Unchanged on a data grant with instr idle.
- While in a granted state, `L2_read`, `L2_write`, `L2_addr` and `L2_wdata` follow the owner's live inputs (combinational mux selected by state). In `ARB_IDLE` all four are 0.
- Response routing:
  - `L2_resp` in `ARB_INSTR` drives `instr_resp` = 1 in the same cycle; in `ARB_DATA` it drives `data_resp` = 1.
  - `L2_resp` in `ARB_IDLE` is ignored.
  - The owner's state returns to `ARB_IDLE` on the next edge.
- `instr_rdata` and `data_rdata` equal `L2_rdata` at all times; only `*_resp` qualifies them.
- Requesters deassert `read`/`write` in the cycle after their `resp`. The mandatory `ARB_IDLE` cycle guarantees a stale request is never re-granted.
- A requester asserting both `read` and `write` forwards both to L2 unchanged; the arbiter performs no checking.
- `busy` = (state != `ARB_IDLE`).

## Timing
- Reset (`rst_n` = 0 at an edge): state `ARB_IDLE`, `streak` = 0.
  - Outputs after reset: `L2_read`/`L2_write`/`busy`/`instr_resp`/`data_resp` = 0; `L2_addr` = 0; `L2_wdata` = 0.
  - `*_rdata` mirror `L2_rdata`.
- Reset mid-transaction abandons the grant; L2 is reset in the same domain.
- Request first seen in `ARB_IDLE` at cycle t: `L2_read`/`L2_write` asserted at t+1.
- `L2_resp` at cycle k: `*_resp` at k (combinational). State returns to `ARB_IDLE` at k+1, and the next grant can be issued at k+2.
- Minimum turnaround between two L2 commands: 2 cycles after `L2_resp`.
- A new request arriving while busy waits; it is never preempted.
- `L2_resp` in the same cycle a grant is taken cannot occur: the grant becomes visible to L2 only at t+1.

## Structure
- Package `arb_pkg`: `arb_state_t` enum (`ARB_IDLE`, `ARB_INSTR`, `ARB_DATA`) and the line width constant `LINE_W` = 256.
- Sub-module `arb_streak_counter`: saturating 4-bit counter with `inc`, `clr` and `limit_hit`, reset synchronously by `rst_n`.
- Top contains the state FSM, the L2 output mux and the response demux.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0 and `busy` = 0. Asserting `L2_resp` = 1 while idle → no `*_resp`.
- `data_read` = 1 with `data_addr` = 0x0000_1000, L2 responds 3 cycles later → `L2_read` = 1 and `L2_addr` = 0x1000 from t+1; `data_resp` = 1 in the `L2_resp` cycle; `L2_read` = 0 the following cycle.
- `instr_read` and `data_write` asserted together in the same cycle → data granted first with `L2_write` = 1; instr granted 2 cycles after that `L2_resp`.
- `instr_read` held while `data_read` re-requests continuously, `STARVE_LIMIT` = 4 → exactly 4 data grants, then an instr grant, with `streak` = 0 afterward.
- `rst_n` pulled low during `ARB_DATA` before `L2_resp` → next cycle state is `ARB_IDLE` and `L2_read` = 0; a subsequent `instr_read` is granted normally.
- Writeback line 0xA5…A5 on `data_wdata` → `L2_wdata` carries the identical 256-bit value while `L2_write` = 1, and is 0 when idle.
